// File: rtl/benes_route_ctrl.sv
// benes_route_ctrl
// Stores per-route Benes switch settings (module-side and slot-side words for
// every stage) and sequences their application to the network: apply, wait
// for the interconnect to settle, then flag the route as active.
// Optional feature macro: BENES_ROUTE_IDENTITY_EN -- when defined, route 0 is
// a hardwired, always-valid identity route (all-zero words) that cannot be
// overwritten; when undefined, route 0 is an ordinary table entry.
module benes_route_ctrl #(
  parameter  int STAGE_NUM  = 9,
  parameter  int SWITCH_NUM = 16,
  parameter  int ROUTE_NUM  = 8,
  parameter  int SETTLE_CYC = 4,
  localparam int RID_W      = (ROUTE_NUM > 1) ? $clog2(ROUTE_NUM) : 1,
  localparam int SID_W      = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // table write port
  input  logic                  i_cfg_valid,
  input  logic [RID_W-1:0]      i_cfg_route,
  input  logic [SID_W-1:0]      i_cfg_stage,
  input  logic [SWITCH_NUM-1:0] i_cfg_module_sw,
  input  logic [SWITCH_NUM-1:0] i_cfg_slot_sw,
  output logic                  o_cfg_ready,
  // route-apply handshake
  input  logic                  i_req_valid,
  input  logic [RID_W-1:0]      i_req_route,
  output logic                  o_req_ready,
  // switch settings driven into the network
  output logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1],
  // status
  output logic                  o_route_active,
  output logic [RID_W-1:0]      o_route_id,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int               CNT_W       = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SID_W-1:0] FIRST_STAGE = '0;
  localparam logic [SID_W-1:0] LAST_STAGE  = SID_W'(STAGE_NUM - 1);

  // Route table payload. Deliberately not reset: the valid bits alone decide
  // whether an entry may be applied, so stale words are harmless.
  logic [SWITCH_NUM-1:0] mod_tbl_q  [0:ROUTE_NUM-1][0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] slot_tbl_q [0:ROUTE_NUM-1][0:STAGE_NUM-1];

  logic [ROUTE_NUM-1:0]  valid_q, valid_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RID_W-1:0]      route_id_q, route_id_d;
  logic                  active_q, active_d;
  logic                  err_q, err_d;
  logic [SWITCH_NUM-1:0] mod_sel_q  [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] mod_sel_d  [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] slot_sel_q [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] slot_sel_d [0:STAGE_NUM-1];

  // Words of the requested route, read from the table before any same-cycle
  // write lands, so a simultaneous write never affects the request.
  logic [SWITCH_NUM-1:0] rd_mod  [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] rd_slot [0:STAGE_NUM-1];

  logic cfg_ready;
  logic req_ready;
  logic cfg_fire;
  logic req_fire;
  logic cfg_stage_ok;
  logic cfg_route_locked;
  logic cfg_write;
  logic cfg_err;
  logic req_is_ident;
  logic req_route_ok;
  logic req_same_active;
  logic req_apply;
  logic req_err;

  // The entry currently driving the network (settling or active) is frozen.
  assign cfg_ready    = !((i_cfg_route == route_id_q) && (state_q != IDLE));
  assign req_ready    = (state_q != SETTLE);
  assign cfg_fire     = i_cfg_valid && cfg_ready;
  assign req_fire     = i_req_valid && req_ready;
  assign cfg_stage_ok = (32'(i_cfg_stage) < 32'(STAGE_NUM));

`ifdef BENES_ROUTE_IDENTITY_EN
  assign cfg_route_locked = (i_cfg_route == '0);
  assign req_is_ident     = (i_req_route == '0);
`else
  assign cfg_route_locked = 1'b0;
  assign req_is_ident     = 1'b0;
`endif

  // A write to a bad stage or to the locked identity route is consumed but dropped.
  assign cfg_write = cfg_fire && cfg_stage_ok && !cfg_route_locked;
  assign cfg_err   = cfg_fire && !(cfg_stage_ok && !cfg_route_locked);

  assign req_route_ok    = (32'(i_req_route) < 32'(ROUTE_NUM)) &&
                           (req_is_ident || valid_q[i_req_route]);
  assign req_same_active = (state_q == ACTIVE) && (i_req_route == route_id_q);
  assign req_err         = req_fire && !req_route_ok;
  assign req_apply       = req_fire && req_route_ok && !req_same_active;

  // Stage 0 opens a rewrite (entry invalid), the last stage closes it (valid).
  always_comb begin
    valid_d = valid_q;
    if (cfg_write) begin
      if (i_cfg_stage == FIRST_STAGE) valid_d[i_cfg_route] = 1'b0;
      if (i_cfg_stage == LAST_STAGE)  valid_d[i_cfg_route] = 1'b1;
    end
  end

  // Select words for the requested route; the identity route reads as zeros.
  always_comb begin
    for (int s = 0; s < STAGE_NUM; s++) begin
      rd_mod[s]  = req_is_ident ? '0 : mod_tbl_q[i_req_route][s];
      rd_slot[s] = req_is_ident ? '0 : slot_tbl_q[i_req_route][s];
    end
  end

  // Next-state logic for the apply/settle/active sequencer and its outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    route_id_d = route_id_q;
    active_d   = active_q;
    err_d      = cfg_err || req_err;
    for (int s = 0; s < STAGE_NUM; s++) begin
      mod_sel_d[s]  = mod_sel_q[s];
      slot_sel_d[s] = slot_sel_q[s];
    end

    if (state_q == SETTLE) begin
      if (cnt_q <= CNT_ONE) begin
        state_d  = ACTIVE;
        active_d = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    // Requests are only taken outside SETTLE, so this never races the countdown.
    if (req_apply) begin
      state_d    = SETTLE;
      cnt_d      = SETTLE_LOAD;
      active_d   = 1'b0;
      route_id_d = i_req_route;
      for (int s = 0; s < STAGE_NUM; s++) begin
        mod_sel_d[s]  = rd_mod[s];
        slot_sel_d[s] = rd_slot[s];
      end
    end
  end

  // Route table payload write.
  always_ff @(posedge clk) begin
    if (cfg_write) begin
      mod_tbl_q[i_cfg_route][i_cfg_stage]  <= i_cfg_module_sw;
      slot_tbl_q[i_cfg_route][i_cfg_stage] <= i_cfg_slot_sw;
    end
  end

  // Control and select registers; reset abandons any settle in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      route_id_q <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      for (int s = 0; s < STAGE_NUM; s++) begin
        mod_sel_q[s]  <= '0;
        slot_sel_q[s] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      route_id_q <= route_id_d;
      active_q   <= active_d;
      err_q      <= err_d;
      for (int s = 0; s < STAGE_NUM; s++) begin
        mod_sel_q[s]  <= mod_sel_d[s];
        slot_sel_q[s] <= slot_sel_d[s];
      end
    end
  end

  assign o_cfg_ready     = cfg_ready;
  assign o_req_ready     = req_ready;
  assign o_module_select = mod_sel_q;
  assign o_slot_select   = slot_sel_q;
  assign o_route_active  = active_q;
  assign o_route_id      = route_id_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_benes_route_ctrl.sv
// Bench for benes_route_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-stamped behavioural model of the route controller.
module tb_benes_route_ctrl;

  localparam int STAGE_NUM  = 9;
  localparam int SWITCH_NUM = 16;
  localparam int ROUTE_NUM  = 8;
  localparam int SETTLE_CYC = 4;
  localparam int RID_W      = 3;
  localparam int SID_W      = 4;
`ifdef BENES_ROUTE_IDENTITY_EN
  localparam bit IDENT = 1'b1;
`else
  localparam bit IDENT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_cfg_valid = 1'b0;
  logic [RID_W-1:0]      i_cfg_route = '0;
  logic [SID_W-1:0]      i_cfg_stage = '0;
  logic [SWITCH_NUM-1:0] i_cfg_module_sw = '0;
  logic [SWITCH_NUM-1:0] i_cfg_slot_sw = '0;
  logic                  o_cfg_ready;
  logic                  i_req_valid = 1'b0;
  logic [RID_W-1:0]      i_req_route = '0;
  logic                  o_req_ready;
  logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1];
  logic                  o_route_active;
  logic [RID_W-1:0]      o_route_id;
  logic                  o_err;

  int checks = 0;
  int errors = 0;

  benes_route_ctrl #(
    .STAGE_NUM (STAGE_NUM),
    .SWITCH_NUM(SWITCH_NUM),
    .ROUTE_NUM (ROUTE_NUM),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cfg_valid    (i_cfg_valid),
    .i_cfg_route    (i_cfg_route),
    .i_cfg_stage    (i_cfg_stage),
    .i_cfg_module_sw(i_cfg_module_sw),
    .i_cfg_slot_sw  (i_cfg_slot_sw),
    .o_cfg_ready    (o_cfg_ready),
    .i_req_valid    (i_req_valid),
    .i_req_route    (i_req_route),
    .o_req_ready    (o_req_ready),
    .o_module_select(o_module_select),
    .o_slot_select  (o_slot_select),
    .o_route_active (o_route_active),
    .o_route_id     (o_route_id),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The network is "applied" at a recorded edge number; it is active once
  // SETTLE_CYC further edges have elapsed.
  logic [SWITCH_NUM-1:0] m_mod  [0:ROUTE_NUM-1][0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] m_slot [0:ROUTE_NUM-1][0:STAGE_NUM-1];
  bit                    m_valid [0:ROUTE_NUM-1];
  bit                    m_applied;
  int                    m_apply_edge;
  int                    m_edge;
  int                    m_id;
  logic [SWITCH_NUM-1:0] m_msel [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] m_ssel [0:STAGE_NUM-1];
  bit                    m_err;

  function automatic bit m_route_ok(int r);
    return (IDENT && r == 0) || m_valid[r];
  endfunction

  function automatic bit m_settling();
    return m_applied && (m_edge < m_apply_edge + SETTLE_CYC);
  endfunction

  function automatic bit m_active();
    return m_applied && !m_settling();
  endfunction

  function automatic bit m_cfg_ready(int r);
    return !(m_applied && r == m_id);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < ROUTE_NUM; r++) m_valid[r] = 1'b0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      m_msel[s] = '0;
      m_ssel[s] = '0;
    end
    m_applied = 1'b0;
    m_apply_edge = 0;
    m_edge = 0;
    m_id = 0;
    m_err = 1'b0;
  endtask

  // One clock edge: advance the model from the inputs present at the edge,
  // then move 1 time unit past the edge so DUT outputs can be sampled.
  task automatic step();
    bit req_acc, cfg_acc, err;
    int r, c, s;
    @(posedge clk);
    r = int'(i_req_route);
    c = int'(i_cfg_route);
    s = int'(i_cfg_stage);
    req_acc = i_req_valid && !m_settling();
    cfg_acc = i_cfg_valid && m_cfg_ready(c);
    m_edge++;
    err = 1'b0;
    if (req_acc) begin
      if (!m_route_ok(r)) begin
        err = 1'b1;
      end else if (!(m_applied && r == m_id)) begin
        m_applied = 1'b1;
        m_apply_edge = m_edge;
        m_id = r;
        for (int k = 0; k < STAGE_NUM; k++) begin
          m_msel[k] = (IDENT && r == 0) ? '0 : m_mod[r][k];
          m_ssel[k] = (IDENT && r == 0) ? '0 : m_slot[r][k];
        end
      end
    end
    if (cfg_acc) begin
      if (s >= STAGE_NUM || (IDENT && c == 0)) begin
        err = 1'b1;
      end else begin
        m_mod[c][s] = i_cfg_module_sw;
        m_slot[c][s] = i_cfg_slot_sw;
        if (s == 0) m_valid[c] = 1'b0;
        if (s == STAGE_NUM - 1) m_valid[c] = 1'b1;
      end
    end
    m_err = err;
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    i_cfg_valid = 1'b0;
    i_req_valid = 1'b0;
  endtask

  task automatic set_cfg(input int r, input int s, input logic [SWITCH_NUM-1:0] mw,
                         input logic [SWITCH_NUM-1:0] sw);
    i_cfg_valid = 1'b1;
    i_cfg_route = RID_W'(r);
    i_cfg_stage = SID_W'(s);
    i_cfg_module_sw = mw;
    i_cfg_slot_sw = sw;
  endtask

  task automatic set_req(input int r);
    i_req_valid = 1'b1;
    i_req_route = RID_W'(r);
  endtask

  task automatic load_route_const(input int r, input logic [SWITCH_NUM-1:0] mw,
                                  input logic [SWITCH_NUM-1:0] sw);
    for (int s = 0; s < STAGE_NUM; s++) begin
      set_cfg(r, s, mw, sw);
      step();
    end
    idle_inputs();
  endtask

  task automatic load_route_rand(input int r);
    for (int s = 0; s < STAGE_NUM; s++) begin
      set_cfg(r, s, SWITCH_NUM'($urandom), SWITCH_NUM'($urandom));
      step();
    end
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== '0 || o_slot_select[s] !== '0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_selects: %0d nonzero stages, expected 0", bad); end
    checks++;
    if (o_route_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", o_route_active); end
    checks++;
    if (o_route_id !== '0) begin errors++; $display("FAIL reset_route_id: got %0d expected 0", o_route_id); end
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", o_req_ready); end
    checks++;
    if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", o_cfg_ready); end
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (o_route_active !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: active=%b req_ready=%b expected 0/1", o_route_active, o_req_ready);
    end
  endtask

  task automatic test_unloaded_request();
    int bad;
    set_req(3);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL unloaded_err: got %b expected 1", o_err); end
    checks++;
    if (o_route_active !== 1'b0) begin errors++; $display("FAIL unloaded_active: got %b expected 0", o_route_active); end
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== '0 || o_slot_select[s] !== '0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL unloaded_selects: %0d nonzero stages, expected 0", bad); end
    step();
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL unloaded_err_pulse: got %b expected 0 one cycle later", o_err); end
  endtask

  task automatic test_load_apply();
    int bad;
    load_route_const(2, 16'hA5A5, 16'h5A5A);
    load_route_rand(4);
    load_route_rand(5);
    set_req(2);
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL apply_req_ready_idle: got %b expected 1", o_req_ready); end
    step();
    idle_inputs();
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== 16'hA5A5 || o_slot_select[s] !== 16'h5A5A) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL apply_selects: %0d stages differ from A5A5/5A5A", bad); end
    checks++;
    if (o_route_id !== 3'd2) begin errors++; $display("FAIL apply_route_id: got %0d expected 2", o_route_id); end
    checks++;
    if (o_route_active !== 1'b0 || o_req_ready !== 1'b0) begin
      errors++; $display("FAIL apply_settle_entry: active=%b req_ready=%b expected 0/0", o_route_active, o_req_ready);
    end
    for (int i = 1; i < SETTLE_CYC; i++) begin
      step();
      checks++;
      if (o_route_active !== 1'b0 || o_module_select[0] !== 16'hA5A5) begin
        errors++; $display("FAIL apply_settling_%0d: active=%b sel0=%h expected 0/a5a5", i, o_route_active, o_module_select[0]);
      end
    end
    step();
    checks++;
    if (o_route_active !== 1'b1 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL apply_active: active=%b req_ready=%b expected 1/1", o_route_active, o_req_ready);
    end
  endtask

  task automatic test_cfg_block();
    set_cfg(2, 0, SWITCH_NUM'($urandom), SWITCH_NUM'($urandom));
    #1;
    checks++;
    if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_block_active_route: got %b expected 0", o_cfg_ready); end
    step();
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL cfg_block_no_err: got %b expected 0", o_err); end
    set_cfg(5, 3, SWITCH_NUM'($urandom), SWITCH_NUM'($urandom));
    #1;
    checks++;
    if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_other_route_ready: got %b expected 1", o_cfg_ready); end
    step();
    idle_inputs();
    checks++;
    if (o_route_active !== 1'b1 || o_err !== 1'b0) begin
      errors++; $display("FAIL cfg_other_route_write: active=%b err=%b expected 1/0", o_route_active, o_err);
    end
  endtask

  task automatic test_reapply();
    int bad;
    set_req(2);
    step();
    idle_inputs();
    checks++;
    if (o_route_active !== 1'b1 || o_route_id !== 3'd2 || o_err !== 1'b0 || o_req_ready !== 1'b1) begin
      errors++; $display("FAIL same_route_hold: active=%b id=%0d err=%b rdy=%b expected 1/2/0/1", o_route_active, o_route_id, o_err, o_req_ready);
    end
    set_req(5);
    step();
    idle_inputs();
    checks++;
    if (o_route_active !== 1'b0 || o_route_id !== 3'd5) begin
      errors++; $display("FAIL switch_route_drop: active=%b id=%0d expected 0/5", o_route_active, o_route_id);
    end
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== m_mod[5][s] || o_slot_select[s] !== m_slot[5][s]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL switch_route_selects: %0d stages differ from route 5 words", bad); end
    repeat (SETTLE_CYC - 1) step();
    checks++;
    if (o_route_active !== 1'b0) begin errors++; $display("FAIL switch_route_early: got %b expected 0 at T+4", o_route_active); end
    step();
    checks++;
    if (o_route_active !== 1'b1 || o_route_id !== 3'd5) begin
      errors++; $display("FAIL switch_route_active: active=%b id=%0d expected 1/5", o_route_active, o_route_id);
    end
    set_req(2);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b0 || o_route_id !== 3'd2 || o_module_select[0] !== 16'hA5A5) begin
      errors++; $display("FAIL route2_intact: err=%b id=%0d sel0=%h expected 0/2/a5a5", o_err, o_route_id, o_module_select[0]);
    end
    repeat (SETTLE_CYC) step();
    checks++;
    if (o_route_active !== 1'b1) begin errors++; $display("FAIL route2_reactive: got %b expected 1", o_route_active); end
  endtask

  task automatic test_same_cycle();
    logic [SWITCH_NUM-1:0] old_m, old_s;
    old_m = m_mod[4][0];
    old_s = m_slot[4][0];
    set_cfg(4, 0, ~old_m, ~old_s);
    set_req(4);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b0 || o_route_id !== 3'd4) begin
      errors++; $display("FAIL same_cycle_apply: err=%b id=%0d expected 0/4", o_err, o_route_id);
    end
    checks++;
    if (o_module_select[0] !== old_m || o_slot_select[0] !== old_s) begin
      errors++; $display("FAIL same_cycle_old_data: sel=%h/%h expected %h/%h", o_module_select[0], o_slot_select[0], old_m, old_s);
    end
    repeat (SETTLE_CYC) step();
    set_req(4);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1 || o_route_active !== 1'b1 || o_route_id !== 3'd4) begin
      errors++; $display("FAIL same_cycle_invalidated: err=%b active=%b id=%0d expected 1/1/4", o_err, o_route_active, o_route_id);
    end
    step();
  endtask

  task automatic test_bad_stage();
    set_cfg(6, 9, 16'hFFFF, 16'hFFFF);
    step();
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL bad_stage_9: err=%b expected 1", o_err); end
    set_cfg(6, 15, 16'hFFFF, 16'hFFFF);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL bad_stage_15: err=%b expected 1", o_err); end
    set_req(6);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1 || o_route_id !== 3'd4) begin
      errors++; $display("FAIL bad_stage_dropped: err=%b id=%0d expected 1/4", o_err, o_route_id);
    end
    step();
  endtask

  task automatic test_reset_mid_settle();
    int bad;
    set_req(5);
    step();
    idle_inputs();
    checks++;
    if (o_req_ready !== 1'b0 || o_route_id !== 3'd5) begin
      errors++; $display("FAIL mid_settle_entry: rdy=%b id=%0d expected 0/5", o_req_ready, o_route_id);
    end
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== '0 || o_slot_select[s] !== '0) bad++;
    checks++;
    if (bad != 0 || o_route_active !== 1'b0 || o_route_id !== '0 || o_err !== 1'b0) begin
      errors++; $display("FAIL async_reset_outputs: badsel=%0d active=%b id=%0d err=%b expected all 0", bad, o_route_active, o_route_id, o_err);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (o_req_ready !== 1'b1 || o_route_active !== 1'b0 || o_cfg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_idle: rdy=%b active=%b cfg_rdy=%b expected 1/0/1", o_req_ready, o_route_active, o_cfg_ready);
    end
    set_req(5);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL reset_clears_valid: err=%b expected 1", o_err); end
  endtask

  task automatic test_route0();
    int bad;
`ifdef BENES_ROUTE_IDENTITY_EN
    set_cfg(0, 8, 16'h1234, 16'h4321);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL ident_cfg_reject: err=%b expected 1", o_err); end
    set_req(0);
    step();
    idle_inputs();
    bad = 0;
    for (int s = 0; s < STAGE_NUM; s++)
      if (o_module_select[s] !== '0 || o_slot_select[s] !== '0) bad++;
    checks++;
    if (bad != 0 || o_err !== 1'b0 || o_route_id !== '0) begin
      errors++; $display("FAIL ident_apply: badsel=%0d err=%b id=%0d expected 0/0/0", bad, o_err, o_route_id);
    end
    repeat (SETTLE_CYC) step();
    checks++;
    if (o_route_active !== 1'b1) begin errors++; $display("FAIL ident_active: got %b expected 1", o_route_active); end
`else
    bad = 0;
    set_req(0);
    step();
    idle_inputs();
    checks++;
    if (o_err !== 1'b1 || o_route_active !== 1'b0) begin
      errors++; $display("FAIL route0_invalid: err=%b active=%b expected 1/0 (bad=%0d)", o_err, o_route_active, bad);
    end
`endif
    step();
  endtask

  task automatic test_random();
    int bad;
    for (int r = 0; r < ROUTE_NUM; r++)
      if (!(IDENT && r == 0)) load_route_rand(r);
    for (int cyc = 0; cyc < 800; cyc++) begin
      i_req_valid = ($urandom_range(0, 99) < 40);
      i_req_route = RID_W'($urandom_range(0, ROUTE_NUM - 1));
      i_cfg_valid = ($urandom_range(0, 99) < 25);
      i_cfg_route = RID_W'($urandom_range(0, ROUTE_NUM - 1));
      i_cfg_stage = ($urandom_range(0, 9) == 0) ? SID_W'($urandom_range(9, 15))
                                                : SID_W'($urandom_range(0, STAGE_NUM - 1));
      i_cfg_module_sw = SWITCH_NUM'($urandom);
      i_cfg_slot_sw = SWITCH_NUM'($urandom);
      #1;
      checks++;
      if (o_cfg_ready !== m_cfg_ready(int'(i_cfg_route)) || o_req_ready !== !m_settling()) begin
        errors++; $display("FAIL rand_ready_c%0d: cfg=%b req=%b expected %b/%b", cyc, o_cfg_ready, o_req_ready, m_cfg_ready(int'(i_cfg_route)), !m_settling());
      end
      step();
      checks++;
      if (o_route_active !== m_active() || o_route_id !== RID_W'(m_id) || o_err !== m_err) begin
        errors++; $display("FAIL rand_status_c%0d: active=%b id=%0d err=%b expected %b/%0d/%b", cyc, o_route_active, o_route_id, o_err, m_active(), m_id, m_err);
      end
      bad = 0;
      for (int s = 0; s < STAGE_NUM; s++)
        if (o_module_select[s] !== m_msel[s] || o_slot_select[s] !== m_ssel[s]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_selects_c%0d: %0d stages differ from model", cyc, bad); end
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unloaded_request();
    test_load_apply();
    test_cfg_block();
    test_reapply();
    test_same_cycle();
    test_bad_stage();
    test_reset_mid_settle();
    test_route0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/benes_route_ctrl.md
BENES_ROUTE_CTRL -- requirements
Module: benes_route_ctrl

Interface
REQ-001 SHALL take parameter STAGE_NUM, default 9, giving the Benes stage count (32-port network).
REQ-002 SHALL take parameter SWITCH_NUM, default 16, giving the switches per stage.
REQ-003 SHALL take parameter ROUTE_NUM, default 8, giving the stored route-table entries; RID_W = clog2(ROUTE_NUM).
REQ-004 SHALL take parameter SETTLE_CYC, default 4, giving the cycles from select change to data-valid through the interconnect registers and network.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_cfg_valid, input, 1, table write request.
REQ-008 SHALL have port i_cfg_route, input, RID_W, the route entry to write.
REQ-009 SHALL have port i_cfg_stage, input, clog2(STAGE_NUM), the stage word to write.
REQ-010 SHALL have ports i_cfg_module_sw and i_cfg_slot_sw, input, SWITCH_NUM each, the R2M and M2R switch bits.
REQ-011 SHALL have port o_cfg_ready, output, 1, write accept.
REQ-012 SHALL have ports i_req_valid (input, 1), i_req_route (input, RID_W) and o_req_ready (output, 1), the route-apply handshake.
REQ-013 SHALL have ports o_module_select and o_slot_select, output, SWITCH_NUM x [0:STAGE_NUM-1], registered switch settings.
REQ-014 SHALL have ports o_route_active (output, 1), o_route_id (output, RID_W) and o_err (output, 1, single-cycle error pulse).

Function
REQ-015 SHALL store per route STAGE_NUM module words, STAGE_NUM slot words and one valid bit.
REQ-016 SHALL treat a cfg transfer as i_cfg_valid && o_cfg_ready.
  - stage 0 write clears the entry's valid bit.
  - stage STAGE_NUM-1 write sets the entry's valid bit.
  - intermediate stages leave the valid bit unchanged.
REQ-017 SHALL deassert o_cfg_ready whenever i_cfg_route equals o_route_id and state is not IDLE; otherwise o_cfg_ready SHALL be 1.
REQ-018 SHALL implement FSM IDLE, SETTLE and ACTIVE.
  - o_req_ready = 1 in IDLE and ACTIVE, 0 in SETTLE.
REQ-019 SHALL handle an accepted request to a valid route R at cycle T as follows:
  - o_module_select, o_slot_select and o_route_id = R registered at T+1.
  - state SETTLE, with a counter loaded to SETTLE_CYC.
  - o_route_active rises at T+1+SETTLE_CYC and state becomes ACTIVE.
REQ-020 SHALL hold selects constant during SETTLE and ACTIVE.
REQ-021 SHALL, for a request in ACTIVE to R equal to o_route_id, stay ACTIVE with no settle and no select change.
  - A request for a different R drops o_route_active at T+1 and re-enters SETTLE.
REQ-022 SHALL, for a request to an invalid route, pulse o_err at T+1, leave selects, state and o_route_active unchanged, and consume the request.
REQ-023 SHALL, on a same-cycle cfg write and request to the same route, resolve the request against the pre-write table contents and valid bit.
REQ-024 SHALL compare stage index i_cfg_stage >= STAGE_NUM, drop the write and pulse o_err.

Reset
REQ-025 SHALL, while rst_n = 0, asynchronously force the following reset values:
  - all valid bits 0
  - all selects 0
  - o_route_id 0, o_route_active 0, o_err 0
  - state IDLE
  - settle counter 0
REQ-026 SHALL not clear table data words on reset; only valid bits gate their use.
REQ-027 SHALL, on reset mid-SETTLE, abandon the settle and come out of reset in IDLE with o_req_ready = 1.

Configuration
REQ-028 SHALL with BENES_ROUTE_IDENTITY_EN defined hardwire route 0 as valid, all-zero (identity) words in both directions, and reject cfg writes to route 0 by accepting them, leaving the table unchanged and pulsing o_err.
REQ-029 SHALL without BENES_ROUTE_IDENTITY_EN treat route 0 as an ordinary writable entry, invalid after reset.

Verification
REQ-030 Reset, then request route 3 (unloaded) -> o_err pulse at T+1; selects remain 0; o_route_active = 0.
REQ-031 Load route 2 stages 0..8 with module word 16'hA5A5 and slot word 16'h5A5A, then request at T -> selects equal those words at T+1; o_route_active = 1 at T+5 (SETTLE_CYC = 4).
REQ-032 While route 2 is ACTIVE, issue a cfg write to route 2 -> o_cfg_ready = 0; a cfg write to route 5 is accepted in the same window.
REQ-033 With route 2 ACTIVE, request route 2 -> no drop of o_route_active; then request a loaded route 5 -> o_route_active = 0 at T+1 and 1 at T+5, o_route_id = 5.
REQ-034 Same-cycle stage-0 write and request to loaded route 4 -> route applied (old contents); a following request to route 4 -> o_err.
REQ-035 Assert rst_n low during SETTLE -> all outputs 0 and o_req_ready = 1 after release. With BENES_ROUTE_IDENTITY_EN: request route 0 -> zero selects and active after 4 cycles; a cfg write to route 0 -> o_err.
